// File: rtl/noc_port_pkg.sv
`default_nettype none
// ============================================================================
// Package     : noc_port_pkg
// Description : Register offsets, STATUS/CONTROL bit positions and helpers
//               shared by the NoC receive port and its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_port_pkg;

  // Avalon word offsets
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_FLUSH   = 2'd3;

  // STATUS bit positions
  localparam int ST_EMPTY    = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_OVF      = 2;
  localparam int ST_DROP_LSB = 8;
  localparam int ST_CNT_LSB  = 16;

  // drop counter width (saturating)
  localparam int DROP_W = 8;

  // CONTROL bit positions
  localparam int CTL_IRQ_EN = 0;

  // FLUSH command bit
  localparam int FLUSH_BIT = 0;

  // Saturating increment for the drop counter: sticks at all-ones.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
  endfunction

endpackage : noc_port_pkg
`default_nettype wire

// File: rtl/noc_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : noc_rx_fifo
// Description : Show-ahead synchronous FIFO with push/pop/flush. Pops on an
//               empty FIFO are ignored; a push while full is accepted only if
//               a pop happens in the same cycle. Flush overrides everything.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_rx_fifo
  import noc_port_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_do_pop;
  logic w_do_push;

  assign empty = (r_count == '0);
  assign full  = (r_count == CNT_W'(DEPTH));
  assign count = r_count;

  // Flush wins over both ports; a full FIFO may accept a word only when a
  // real pop frees a slot in the same cycle.
  assign w_do_pop  = pop & ~empty & ~flush;
  assign w_do_push = push & (~full | w_do_pop) & ~flush;

  // Head is presented combinationally; an empty FIFO reads as zero so stale
  // storage never leaks out.
  assign head = empty ? '0 : r_mem[r_rd_ptr];

  // Storage array: written at the tail, no reset needed (guarded by count).
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2**PTR_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : noc_rx_fifo
`default_nettype wire

// File: rtl/noc_32_in_port.sv
`default_nettype none
// ============================================================================
// Module      : noc_32_in_port
// Description : Avalon-MM slave that buffers 32-bit NoC words for the Nios.
//               DATA pops the FIFO head, STATUS reports occupancy and drops,
//               CONTROL holds the irq enable, FLUSH empties the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_32_in_port
  import noc_port_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              irq
);

  logic [DATA_W-1:0] w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;

  logic              w_bus_wr;
  logic              w_data_rd;
  logic              w_pop_eff;
  logic              w_flush;
  logic              w_ovf_clr;
  logic              w_ctl_wr;
  logic              w_drop;

  logic              r_irq_en;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_cnt;

  logic [31:0]       w_status;
  logic [31:0]       w_control;

  // Avalon command decode
  assign w_bus_wr  = chipselect & ~write_n;
  assign w_data_rd = chipselect & ~read_n & (address == ADDR_DATA);
  assign w_flush   = w_bus_wr & (address == ADDR_FLUSH)   & writedata[FLUSH_BIT];
  assign w_ovf_clr = w_bus_wr & (address == ADDR_STATUS)  & writedata[ST_OVF];
  assign w_ctl_wr  = w_bus_wr & (address == ADDR_CONTROL);

  // A pop only frees a slot when there is something to pop.
  assign w_pop_eff = w_data_rd & ~w_empty;

  // Incoming word is lost when the buffer is full and nothing leaves this
  // cycle; words discarded by a flush are not counted as drops.
  assign w_drop = in_valid & w_full & ~w_pop_eff & ~w_flush;

  noc_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (in_valid),
    .pop     (w_data_rd),
    .flush   (w_flush),
    .wr_data (in_data),
    .head    (w_head),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  // CONTROL register: irq enable, takes effect at the write edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_en <= 1'b0;
    end else if (w_ctl_wr) begin
      r_irq_en <= writedata[CTL_IRQ_EN];
    end
  end

  // Sticky overflow and saturating drop counter; a drop in the same cycle as
  // a clear wins so the new loss is never hidden from software.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      r_drop_cnt <= w_ovf_clr ? DROP_W'(1) : sat_inc(r_drop_cnt);
    end else if (w_ovf_clr) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  // STATUS and CONTROL read images; unused bits read zero.
  always_comb begin
    w_status                          = '0;
    w_status[ST_EMPTY]                = w_empty;
    w_status[ST_FULL]                 = w_full;
    w_status[ST_OVF]                  = r_overflow;
    w_status[ST_DROP_LSB +: DROP_W]   = r_drop_cnt;
    w_status[ST_CNT_LSB  +: CNT_W]    = w_count;
    w_control                         = '0;
    w_control[CTL_IRQ_EN]             = r_irq_en;
  end

  // Zero-wait-state read mux; DATA shows the head (zero when empty).
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = 32'(w_head);
      ADDR_STATUS:  readdata = w_status;
      ADDR_CONTROL: readdata = w_control;
      default:      readdata = '0;
    endcase
  end

  // Level interrupt from registered state only.
  assign irq = r_irq_en & ~w_empty;

endmodule : noc_32_in_port
`default_nettype wire

// File: tb/tb_noc_32_in_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_32_in_port
// Description : Self-checking bench for noc_32_in_port using a queue
//               scoreboard of expected FIFO contents plus a drop model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_32_in_port;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] in_data;
  logic        in_valid;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  bit          m_ovf;
  int          m_drop;

  always #5 clk = ~clk;

  noc_32_in_port #(
    .DATA_W (32),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .irq        (irq)
  );

  // expected STATUS image from the bench model
  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = (exp_q.size() == 0);
    s[1]     = (exp_q.size() == DEPTH);
    s[2]     = m_ovf;
    s[15:8]  = 8'(m_drop);
    s[19:16] = CNT_W'(exp_q.size());
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [31:0] w);
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
    else begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
  endtask

  task automatic drive_push(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    model_push(w);
    step();
    in_valid = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic read_data(output logic [31:0] d);
    address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
    #1;
    d = readdata;
    step();
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  function automatic logic [31:0] model_pop();
    if (exp_q.size() == 0) return 32'h0;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0; address = '0; chipselect = 0; read_n = 1; write_n = 1;
    writedata = '0; in_data = '0; in_valid = 0;
    exp_q.delete(); m_ovf = 0; m_drop = 0;
    step(); step();
    peek(2'd1, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_status got %h want %h", d, 32'h1); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    peek(2'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", d); end
    peek(2'd2, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_control got %h want 0", d); end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [31:0] d, e;
    bus_write(2'd2, 32'h1);
    in_valid = 1'b1; in_data = 32'hDEADBEEF; model_push(in_data);
    step();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq_rise got %b want 1", irq); end
    in_data = 32'h12345678; model_push(in_data);
    step();
    in_valid = 1'b0;
    peek(2'd1, d);
    checks++; if (d !== 32'h0002_0000) begin errors++; $display("FAIL basic_status2 got %h want %h", d, 32'h0002_0000); end
    read_data(d); e = model_pop();
    checks++; if (d !== 32'hDEADBEEF || e !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_data0 got %h want %h", d, e); end
    peek(2'd1, d);
    checks++; if (d !== model_status()) begin errors++; $display("FAIL basic_status1 got %h want %h", d, model_status()); end
    read_data(d); e = model_pop();
    checks++; if (d !== e) begin errors++; $display("FAIL basic_data1 got %h want %h", d, e); end
    peek(2'd1, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL basic_status0 got %h want %h", d, 32'h1); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_fall got %b want 0", irq); end
  endtask

  task automatic test_empty_simul();
    logic [31:0] d, e;
    in_valid = 1'b1; in_data = 32'h55;
    address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
    #1;
    d = readdata;
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL empty_simul_read got %h want 0", d); end
    model_push(32'h55);
    step();
    in_valid = 1'b0; chipselect = 1'b0; read_n = 1'b1;
    peek(2'd1, d);
    checks++; if (d !== model_status()) begin errors++; $display("FAIL empty_simul_status got %h want %h", d, model_status()); end
    read_data(d); e = model_pop();
    checks++; if (d !== e) begin errors++; $display("FAIL empty_simul_data got %h want %h", d, e); end
  endtask

  task automatic test_full_simul();
    logic [31:0] d, e;
    for (int i = 0; i < DEPTH; i++) drive_push(32'h100 + 32'(i));
    peek(2'd1, d);
    checks++; if (d !== 32'h0008_0002) begin errors++; $display("FAIL full_status got %h want %h", d, 32'h0008_0002); end
    in_valid = 1'b1; in_data = 32'h200;
    address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
    #1;
    d = readdata; e = model_pop();
    checks++; if (d !== e) begin errors++; $display("FAIL full_simul_read got %h want %h", d, e); end
    model_push(32'h200);
    step();
    in_valid = 1'b0; chipselect = 1'b0; read_n = 1'b1;
    peek(2'd1, d);
    checks++; if (d !== 32'h0008_0002) begin errors++; $display("FAIL full_simul_status got %h want %h", d, 32'h0008_0002); end
    for (int i = 0; i < DEPTH; i++) begin
      read_data(d); e = model_pop();
      checks++; if (d !== e) begin errors++; $display("FAIL full_drain[%0d] got %h want %h", i, d, e); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d, e;
    for (int i = 0; i < 10; i++) drive_push(32'(i));
    peek(2'd1, d);
    checks++; if (d !== 32'h0008_0206) begin errors++; $display("FAIL ovf_status got %h want %h", d, 32'h0008_0206); end
    for (int i = 0; i < DEPTH; i++) begin
      read_data(d); e = model_pop();
      checks++; if (d !== 32'(i)) begin errors++; $display("FAIL ovf_data[%0d] got %h want %h", i, d, e); end
    end
    bus_write(2'd1, 32'h4);
    m_ovf = 0; m_drop = 0;
    peek(2'd1, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL ovf_clear got %h want %h", d, 32'h1); end
  endtask

  task automatic test_flush();
    logic [31:0] d, e;
    for (int i = 0; i < 9; i++) drive_push(32'h300 + 32'(i));
    for (int i = 0; i < 5; i++) begin
      read_data(d); e = model_pop();
      checks++; if (d !== e) begin errors++; $display("FAIL flush_pre[%0d] got %h want %h", i, d, e); end
    end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL flush_irq_pre got %b want 1", irq); end
    address = 2'd3; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
    in_valid = 1'b1; in_data = 32'hBAD;
    step();
    chipselect = 1'b0; write_n = 1'b1; in_valid = 1'b0; writedata = '0;
    exp_q.delete();
    peek(2'd1, d);
    checks++; if (d !== 32'h0000_0105) begin errors++; $display("FAIL flush_status got %h want %h", d, 32'h0000_0105); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL flush_irq got %b want 0", irq); end
    peek(2'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL flush_data got %h want 0", d); end
    bus_write(2'd1, 32'h4);
    m_ovf = 0; m_drop = 0;
  endtask

  task automatic test_wrap();
    logic [31:0] d, e;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      in_valid = 1'b1; in_data = 32'hA000 + 32'(i);
      if ((i % 4) != 0 && exp_q.size() > 0) begin
        address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
        #1;
        d = readdata; e = model_pop();
        checks++; if (d !== e) begin errors++; $display("FAIL wrap_stream[%0d] got %h want %h", i, d, e); end
      end
      model_push(in_data);
      step();
      chipselect = 1'b0; read_n = 1'b1;
    end
    in_valid = 1'b0;
    peek(2'd1, d);
    checks++; if (d !== model_status()) begin errors++; $display("FAIL wrap_status got %h want %h", d, model_status()); end
    while (exp_q.size() > 0) begin
      read_data(d); e = model_pop();
      checks++; if (d !== e) begin errors++; $display("FAIL wrap_drain got %h want %h", d, e); end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] d;
    for (int i = 0; i < DEPTH + 300; i++) drive_push(32'h700 + 32'(i));
    peek(2'd1, d);
    checks++; if (d !== 32'h0008_FF06) begin errors++; $display("FAIL sat_status got %h want %h", d, 32'h0008_FF06); end
    bus_write(2'd3, 32'h1);
    exp_q.delete();
    bus_write(2'd1, 32'h4);
    m_ovf = 0; m_drop = 0;
    peek(2'd1, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL sat_clear got %h want %h", d, 32'h1); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, e;
    bus_write(2'd2, 32'h1);
    for (int i = 0; i < 3; i++) drive_push(32'h900 + 32'(i));
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rstmid_irq_pre got %b want 1", irq); end
    in_valid = 1'b1; in_data = 32'h9FF;
    #3;
    reset_n = 1'b0;
    exp_q.delete(); m_ovf = 0; m_drop = 0;
    #1;
    peek(2'd1, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL rstmid_status got %h want %h", d, 32'h1); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rstmid_irq got %b want 0", irq); end
    peek(2'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rstmid_data got %h want 0", d); end
    step();
    in_valid = 1'b0;
    reset_n = 1'b1;
    step();
    peek(2'd2, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rstmid_control got %h want 0", d); end
    drive_push(32'hCAFE);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rstmid_irq_disabled got %b want 0", irq); end
    read_data(d); e = model_pop();
    checks++; if (d !== e) begin errors++; $display("FAIL rstmid_data_after got %h want %h", d, e); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_simul();
    test_full_simul();
    test_overflow();
    test_flush();
    test_wrap();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_noc_32_in_port
`default_nettype wire

// File: doc/noc_32_in_port.md
# noc_32_in_port

Avalon-MM slave peripheral that receives 32-bit words from the NoC network interface and buffers them for the Nios II processor. It is the receive-side counterpart of the 32-bit NoC output PIO. Words arrive on a strobe-only NoC port with no backpressure and are stored in an internal FIFO. The processor pops words through a zero-wait-state register map, and the block raises a level interrupt while data is pending.

## Interface
Parameters:
- DATA_W, 32, NoC word width; the Avalon data width is also 32.
- DEPTH, 8, FIFO depth in words; must be a power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  Avalon word offset.
- chipselect  in  1  Avalon slave select.
- read_n  in  1  Avalon read strobe, active-low.
- write_n  in  1  Avalon write strobe, active-low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data; combinational, zero wait states.
- in_data  in  DATA_W  NoC receive word.
- in_valid  in  1  NoC word strobe; one word per cycle while high.
- irq  out  1  level interrupt to the Nios.

## Operation
Register map (word offsets):
- 0 DATA (read only).
  - readdata is the FIFO head, or 0 if empty.
  - A read (chipselect & ~read_n & address==0) pops one word when non-empty.
  - A read when empty has no effect.
- 1 STATUS.
  - [0] empty; [1] full; [2] overflow (sticky); [15:8] drop_count (saturates at 255); [16+CNT_W-1:16] count; other bits 0.
  - Writing 1 to bit 2 clears overflow and drop_count.
- 2 CONTROL (R/W).
  - [0] irq_en; other bits read 0.
- 3 FLUSH.
  - Writing 1 to bit 0 empties the FIFO: pointers and count go to 0.
  - Flush does not clear overflow or drop_count.
  - Reads return 0.

Push and pop rules:
- Push: in_valid high and (FIFO not full, or a pop occurs in the same cycle) → word written at the tail.
- Drop: in_valid high while full with no same-cycle pop → word discarded; overflow set to 1; drop_count incremented unless already 255.
- Push and pop in the same cycle: both take effect and count is unchanged.
  - Exception: when the FIFO is empty, the pop is ignored and only the push happens.
- Flush together with in_valid in the same cycle: flush wins and the incoming word is discarded, not counted as a drop.
- Clearing overflow together with a drop in the same cycle: the drop wins (overflow=1, drop_count=1).
- Pointers wrap modulo DEPTH. count ranges over 0..DEPTH.
- irq = irq_en & ~empty, driven from registered state only.
- A reset mid-operation returns all state to reset values immediately. Buffered words are lost.

## Timing
Reset values:
- FIFO empty, count=0, overflow=0, drop_count=0, irq_en=0.
- Outputs: irq=0; readdata follows the reset state (STATUS reads 0x00000001).

Latency and timing rules:
- in_valid sampled at edge N → the word is visible at DATA, count updated, and irq asserted (if enabled) during cycle N+1.
- A DATA read returns the current head combinationally in the same cycle. The pop takes effect at the following edge, so the next head is visible one cycle later.
- Back-to-back DATA reads on consecutive cycles return consecutive words.
- CONTROL and FLUSH writes take effect at the write edge.
- irq deasserts the cycle after the pop that empties the FIFO.
- Sustained rates: one push and one pop per cycle.

## Structure
Shared package noc_port_pkg holds:
- register offsets ADDR_DATA/ADDR_STATUS/ADDR_CONTROL/ADDR_FLUSH;
- STATUS bit positions (ST_EMPTY, ST_FULL, ST_OVF, ST_DROP_LSB, ST_CNT_LSB);
- the CONTROL bit position CTL_IRQ_EN.

Sub-module noc_rx_fifo:
- parameterised DATA_W/DEPTH synchronous FIFO with push/pop/flush inputs;
- head/count/full/empty outputs;
- show-ahead head output.

The top level holds the Avalon decode, overflow/drop logic, CONTROL register, and irq.

## Test plan
- Reset: assert reset_n=0 mid-stream → STATUS=0x00000001, irq=0, DATA reads 0.
- Basic path: push 0xDEADBEEF, 0x12345678 on consecutive cycles with irq_en=1 → irq high from the next cycle; two DATA reads return both words in order; STATUS count goes 2→1→0; irq low after the last pop.
- Overflow: with DEPTH=8, push 10 words 0x0..0x9 without reads → full=1, overflow=1, drop_count=2; DATA reads return 0x0..0x7. Writing 0x4 to STATUS clears overflow and drop_count.
- Simultaneous events while full: push and pop in the same cycle → count stays 8, no drop.
- Simultaneous events while empty: push and pop in the same cycle → count becomes 1 and the read returns 0.
- Flush: flush with in_valid high in the same cycle on 3 stored words → count=0, drop_count unchanged, irq low.
- Wrap and saturation:
  - stream 3×DEPTH words interleaved with reads → data order preserved across pointer wrap;
  - 300 drops → drop_count=255.
